// File: rtl/ex_div.sv
// ex_div -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// One operation is accepted in IDLE. The divider then performs one restoring
// step per clock for XLEN clocks, and busy_o stalls the pipeline while it works.
// The result leaves as a single-cycle register-file write (wen_o/w_addr_o/w_data_o).
// Divide-by-zero and signed overflow bypass the iteration and finish one clock
// after accept.
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   defined   : when |dividend| < |divisor| (divisor nonzero), the result is
//               ready one clock after accept (quotient 0, remainder dividend).
//   undefined : those operands take the full iterative path.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous reset, active-low
//   start_i     request, sampled only in IDLE
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i  rs1 value, sampled with start_i
//   divisor_i   rs2 value, sampled with start_i
//   rd_addr_i   destination register, sampled with start_i
//   flush_i     abort the current operation, returning to IDLE with no write
//   busy_o      high from accept until the return to IDLE
//   wen_o       one-cycle result write strobe
//   w_addr_o    destination address, zero when wen_o is low
//   w_data_o    result, zero when wen_o is low
module ex_div #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [XLEN-1:0]   dividend_i,
  input  logic [XLEN-1:0]   divisor_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              wen_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [XLEN-1:0]   w_data_o
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;     // partial remainder (magnitude)
  logic [XLEN-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic              spec_q, spec_d;   // quo_q/rem_q already hold final values
  logic              busy_q, busy_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [XLEN-1:0]   w_data_q, w_data_d;

  // Operand conditioning at accept time
  logic            signed_op_s, a_neg_s, b_neg_s, ovf_s;
  logic [XLEN-1:0] abs_a_s, abs_b_s;

  assign signed_op_s = ~op_i[0];
  assign a_neg_s     = signed_op_s & dividend_i[XLEN-1];
  assign b_neg_s     = signed_op_s & divisor_i[XLEN-1];
  assign abs_a_s     = a_neg_s ? -dividend_i : dividend_i;
  assign abs_b_s     = b_neg_s ? -divisor_i  : divisor_i;
  assign ovf_s       = signed_op_s & (dividend_i == MIN_NEG) & (&divisor_i);

  // One restoring step. The shifted remainder can reach 2*divisor, hence the
  // extra bit; the borrow of the trial subtract decides the quotient bit.
  logic [XLEN:0]   rem_sh_s, trial_s;
  logic            q_bit_s;
  logic [XLEN-1:0] rem_step_s, quo_step_s, quo_fix_s, rem_fix_s;

  assign rem_sh_s   = {rem_q, quo_q[XLEN-1]};
  assign trial_s    = rem_sh_s - {1'b0, dvs_q};
  assign q_bit_s    = ~trial_s[XLEN];
  assign rem_step_s = q_bit_s ? trial_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_step_s = {quo_q[XLEN-2:0], q_bit_s};
  assign quo_fix_s  = neg_quo_q ? -quo_step_s : quo_step_s;
  assign rem_fix_s  = neg_rem_q ? -rem_step_s : rem_step_s;

  logic [XLEN-1:0] res_s;

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    rd_d      = rd_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    spec_d    = spec_q;
    wen_d     = 1'b0;
    w_addr_d  = {ADDR_W{1'b0}};
    w_data_d  = {XLEN{1'b0}};
    res_s     = {XLEN{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_CALC;
          cnt_d     = {CNT_W{1'b0}};
          rd_d      = rd_addr_i;
          sel_rem_d = op_i[1];
          neg_quo_d = a_neg_s ^ b_neg_s;
          neg_rem_d = a_neg_s;
          dvs_d     = abs_b_s;
          rem_d     = {XLEN{1'b0}};
          quo_d     = abs_a_s;
          spec_d    = 1'b0;
          if (divisor_i == {XLEN{1'b0}}) begin
            spec_d = 1'b1;
            quo_d  = {XLEN{1'b1}};
            rem_d  = dividend_i;
          end else if (ovf_s) begin
            spec_d = 1'b1;
            quo_d  = MIN_NEG;
            rem_d  = {XLEN{1'b0}};
`ifdef DIV_EARLY_OUT_EN
          end else if (abs_a_s < abs_b_s) begin
            spec_d = 1'b1;
            quo_d  = {XLEN{1'b0}};
            rem_d  = dividend_i;
`endif
          end else begin
            spec_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (spec_q) begin
          state_d = S_DONE;
          res_s   = sel_rem_q ? rem_q : quo_q;
        end else begin
          rem_d = rem_step_s;
          quo_d = quo_step_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d = S_DONE;
            res_s   = sel_rem_q ? rem_fix_s : quo_fix_s;
          end else begin
            state_d = S_CALC;
          end
        end
        // x0 writes keep full timing but never strobe
        if ((state_d == S_DONE) && (rd_q != {ADDR_W{1'b0}})) begin
          wen_d    = 1'b1;
          w_addr_d = rd_q;
          w_data_d = res_s;
        end else begin
          wen_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush beats both a new request and a pending write
    if (flush_i) begin
      state_d  = S_IDLE;
      wen_d    = 1'b0;
      w_addr_d = {ADDR_W{1'b0}};
      w_data_d = {XLEN{1'b0}};
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      rd_q      <= {ADDR_W{1'b0}};
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      spec_q    <= 1'b0;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      w_addr_q  <= {ADDR_W{1'b0}};
      w_data_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      rd_q      <= rd_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      spec_q    <= spec_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
    end
  end

  assign busy_o   = busy_q;
  assign wen_o    = wen_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        wen_o;
  logic [4:0]  w_addr_o;
  logic [31:0] w_data_o;

  always #5 clk = ~clk;

  ex_div #(.XLEN(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .wen_o      (wen_o),
    .w_addr_o   (w_addr_o),
    .w_data_o   (w_data_o)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_e;
  bit  mon_en = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write must match the oldest expected write
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (wen_o) begin
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%h", w_addr_o, w_data_o);
        end else begin
          mon_e = sb_q.pop_front();
          if (w_addr_o !== mon_e.addr || w_data_o !== mon_e.data) begin
            failures++;
            $display("FAIL write_value actual=%0d/%h expected=%0d/%h",
                     w_addr_o, w_data_o, mon_e.addr, mon_e.data);
          end
        end
      end else if (w_addr_o !== 5'd0 || w_data_o !== 32'd0) begin
        failures++;
        $display("FAIL idle_outputs_zero actual=%0d/%h expected=0/0", w_addr_o, w_data_o);
      end
    end
  end

  // Reference result using the simulator's own arithmetic
  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : 32'h8000_0000;
    if (!op[0]) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!op[0] && a[31]) ? (32'd0 - a) : a;
    mb = (!op[0] && b[31]) ? (32'd0 - b) : b;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    if (ma == mb) return 32;
    return 32;
  endfunction

  // Caller is just after an edge; the next edge is E0
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_data, input string name);
    int lat, wen_k, idle_k;
    wr_t e;
    lat = exp_lat(op, a, b);
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd; start_i = 1'b1;
    if (rd != 5'd0) begin
      e.addr = rd; e.data = exp_data;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    check({name, "_busy_e0"}, 32'(busy_o), 32'd1);
    wen_k = -1; idle_k = -1;
    for (int k = 1; k <= 40 && idle_k < 0; k++) begin
      @(posedge clk); #1;
      if (wen_o && wen_k < 0) wen_k = k;
      if (!busy_o) idle_k = k;
    end
    check({name, "_wen_cycle"}, 32'(wen_k), (rd != 5'd0) ? 32'(lat) : 32'hFFFF_FFFF);
    check({name, "_idle_cycle"}, 32'(idle_k), 32'(lat + 1));
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; op_i = 2'd0; dividend_i = 32'd0; divisor_i = 32'd0;
    rd_addr_i = 5'd0; flush_i = 1'b0;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF};
    vecs[3]  = '{2'b11, 32'd7,          32'hFFFF_FFFE,  5'd3,  32'd7};
    vecs[4]  = '{2'b00, 32'h55,         32'd0,          5'd4,  32'hFFFF_FFFF};
    vecs[5]  = '{2'b11, 32'h55,         32'd0,          5'd6,  32'h55};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0};
    vecs[8]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd10, 32'd1};
    vecs[9]  = '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD};
    vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF};
    vecs[11] = '{2'b11, 32'd0,          32'd5,          5'd13, 32'd0};
    vecs[12] = '{2'b00, 32'h8000_0000,  32'd2,          5'd31, 32'hC000_0000};
    vecs[13] = '{2'b01, 32'd100,        32'd7,          5'd0,  32'd14};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_wen", 32'(wen_o), 32'd0);
    check("reset_addr", 32'(w_addr_o), 32'd0);
    check("reset_data", w_data_o, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      run_op(op, a, b, 5'($urandom_range(1, 31)), ref_res(op, a, b), $sformatf("rnd%0d", i));
    end

    // Flush at E10, then a fresh op accepted at E11
    op_i = 2'b01; dividend_i = 32'd1000; divisor_i = 32'd3; rd_addr_i = 5'd7; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_wen", 32'(wen_o), 32'd0);
    run_op(2'b01, 32'd1000, 32'd3, 5'd7, 32'd333, "after_flush");

    // Flush wins over start in IDLE
    op_i = 2'b01; dividend_i = 32'd9; divisor_i = 32'd3; rd_addr_i = 5'd7;
    start_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    check("flush_start_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    check("flush_start_busy2", 32'(busy_o), 32'd0);

    // Reset at E5 mid-operation
    op_i = 2'b00; dividend_i = 32'hFFFF_FF9C; divisor_i = 32'd3; rd_addr_i = 5'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_wen", 32'(wen_o), 32'd0);
    check("midrst_addr", 32'(w_addr_o), 32'd0);
    check("midrst_data", w_data_o, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("midrst_still_idle", 32'(busy_o), 32'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
